// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared CPU register-file definitions.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   reg_addr_t          : register address type for the default register count
//   REG_ZERO            : address of the hardwired-zero register
package cpu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_AW   = $clog2(NREG_DEF);

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- per-register "result pending" bits plus a running count.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   alloc_i        : mark alloc_addr_i pending on this edge
//   alloc_addr_i   : register to mark pending (register 0 is ignored)
//   clr_en_i       : per write port, clear the pending bit of clr_addr_i
//   clr_addr_i     : per write port, register whose pending bit is cleared
//   busy_o         : pending bit of every register (bit 0 always 0)
//   nbusy_o        : number of pending registers, registered alongside busy_o
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NCLR = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_i,
  input  logic [AW-1:0]             alloc_addr_i,
  input  logic [NCLR-1:0]           clr_en_i,
  input  logic [NCLR-1:0][AW-1:0]   clr_addr_i,
  output logic [NREG-1:0]           busy_o,
  output logic [AW:0]               nbusy_o
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     nbusy_q, nbusy_d;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int k = 1; k < NREG; k++) begin
      cnt = cnt + {{AW{1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  // Clears are applied before the set so a new producer allocated on the
  // same edge as the old producer's write-back keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NCLR; i++) begin
      if (clr_en_i[i]) begin
        busy_d[clr_addr_i[i]] = 1'b0;
      end
    end
    if (alloc_i && (alloc_addr_i != ZERO_A)) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    // Count is derived from the next state so it never lags the busy bits.
    nbusy_d = popcount(busy_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign busy_o  = busy_q;
  assign nbusy_o = nbusy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-port register file with a pending-result scoreboard.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (clears data, busy bits, count)
//   ra / rd  : NRD combinational read ports (address / data)
//   rbusy    : pending bit of each read address
//   we/wa/wd : NWR write ports; highest port index wins on address collision
//   alloc    : mark alloc_a pending (new producer issued)
//   nbusy    : number of pending registers
// Register 0 reads as zero, is never pending, and ignores writes and allocs.
// Build option REGFILE_BYPASS_EN: forward same-cycle write data (and the
// resulting pending state) to the read ports instead of showing only the
// pre-edge contents.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NRD-1:0][AW-1:0]    ra,
  output logic [NRD-1:0][XLEN-1:0]  rd,
  output logic [NRD-1:0]            rbusy,
  input  logic [NWR-1:0]            we,
  input  logic [NWR-1:0][AW-1:0]    wa,
  input  logic [NWR-1:0][XLEN-1:0]  wd,
  input  logic                      alloc,
  input  logic [AW-1:0]             alloc_a,
  output logic [AW:0]               nbusy
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] busy;

  // Ascending port order makes the highest-index writer win a collision.
  always_comb begin
    rf_d = rf_q;
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && (wa[i] != ZERO_A)) begin
        rf_d[wa[i]] = wd[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // A write-back clears the pending bit even for register 0; that bit is
  // held at zero inside the scoreboard anyway.
  reg_scoreboard #(
    .NREG (NREG),
    .NCLR (NWR)
  ) u_sb (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_i      (alloc),
    .alloc_addr_i (alloc_a),
    .clr_en_i     (we),
    .clr_addr_i   (wa),
    .busy_o       (busy),
    .nbusy_o      (nbusy)
  );

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd[j]    = '0;
      rbusy[j] = 1'b0;
      if (ra[j] != ZERO_A) begin
        rd[j]    = rf_q[ra[j]];
        rbusy[j] = busy[ra[j]];
      end
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i] == ra[j]) && (ra[j] != ZERO_A)) begin
          rd[j]    = wd[i];
          // The write retires the old producer; only a same-edge alloc
          // of this register keeps it pending.
          rbusy[j] = alloc && (alloc_a == ra[j]);
        end
      end
      // Forwarded inputs must not leak through while reset holds the array.
      if (rst) begin
        rd[j]    = '0;
        rbusy[j] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NRD-1:0][AW-1:0]    ra = '0;
  logic [NRD-1:0][XLEN-1:0]  rd;
  logic [NRD-1:0]            rbusy;
  logic [NWR-1:0]            we = '0;
  logic [NWR-1:0][AW-1:0]    wa = '0;
  logic [NWR-1:0][XLEN-1:0]  wd = '0;
  logic                      alloc = 1'b0;
  logic [AW-1:0]             alloc_a = '0;
  logic [AW:0]               nbusy;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: plain arrays updated by the architectural rules.
  logic [XLEN-1:0] m_rf   [NREG];
  bit              m_busy [NREG];

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .alloc(alloc), .alloc_a(alloc_a),
    .nbusy(nbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_rf[r]   = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NWR; i++)
        if (we[i] && wa[i] != 0) m_rf[wa[i]] = wd[i];
      for (int i = 0; i < NWR; i++)
        if (we[i]) m_busy[wa[i]] = 1'b0;
      if (alloc && alloc_a != 0) m_busy[alloc_a] = 1'b1;
    end
  end

  function automatic int model_nbusy();
    int c = 0;
    for (int r = 1; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  always @(negedge clk) begin
    for (int j = 0; j < NRD; j++) begin
      logic [XLEN-1:0] e_rd;
      logic            e_rb;
      e_rd = (ra[j] == 0) ? '0 : m_rf[ra[j]];
      e_rb = (ra[j] == 0) ? 1'b0 : m_busy[ra[j]];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && wa[i] == ra[j] && ra[j] != 0) begin
          e_rd = wd[i];
          e_rb = alloc && (alloc_a == ra[j]);
        end
      end
      if (rst) begin
        e_rd = '0;
        e_rb = 1'b0;
      end
`endif
      chk($sformatf("model_rd%0d", j), rd[j], e_rd);
      chk($sformatf("model_rbusy%0d", j), XLEN'(rbusy[j]), XLEN'(e_rb));
    end
    chk("model_nbusy", XLEN'(nbusy), XLEN'(model_nbusy()));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; alloc = 1'b0; alloc_a = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ra[0] = 5'd5;
    @(negedge clk);
    chk("reset_nbusy", XLEN'(nbusy), 32'd0);
    chk("reset_rd0", rd[0], 32'd0);

    // Single write, read back next cycle.
    next();
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    next();
    idle();
    @(negedge clk);
    chk("wr_x5_rd0", rd[0], 32'hDEADBEEF);
    chk("wr_x5_rbusy0", XLEN'(rbusy[0]), 32'd0);

    // Collision: port 1 wins.
    next();
    we = 2'b11; wa[1] = 5'd7; wa[0] = 5'd7; wd[1] = 32'h2222; wd[0] = 32'h1111;
    ra[1] = 5'd7;
    next();
    idle();
    @(negedge clk);
    chk("collide_x7", rd[1], 32'h2222);

    // Writes and allocs to register 0 are ignored.
    next();
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; alloc = 1'b1; alloc_a = 5'd0;
    ra[0] = 5'd0;
    next();
    idle();
    @(negedge clk);
    chk("x0_rd0", rd[0], 32'd0);
    chk("x0_rbusy0", XLEN'(rbusy[0]), 32'd0);
    chk("x0_nbusy", XLEN'(nbusy), 32'd0);

    // Scoreboard sequence.
    next();
    alloc = 1'b1; alloc_a = 5'd3;
    next();
    alloc_a = 5'd4;
    next();
    idle();
    ra[0] = 5'd3;
    @(negedge clk);
    chk("alloc_nbusy2", XLEN'(nbusy), 32'd2);
    chk("alloc_rbusy_x3", XLEN'(rbusy[0]), 32'd1);
    next();
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h33;
    next();
    idle();
    @(negedge clk);
    chk("wb_x3_nbusy1", XLEN'(nbusy), 32'd1);
    chk("wb_x3_rbusy", XLEN'(rbusy[0]), 32'd0);
    next();
    we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'h44; alloc = 1'b1; alloc_a = 5'd4;
    next();
    idle();
    ra[0] = 5'd4;
    @(negedge clk);
    chk("realloc_x4_rbusy", XLEN'(rbusy[0]), 32'd1);
    chk("realloc_x4_rd", rd[0], 32'h44);
    chk("realloc_nbusy1", XLEN'(nbusy), 32'd1);

    // Same-cycle write and read of x9.
    next();
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hAAAA;
    next();
    wd[0] = 32'h1234; ra[0] = 5'd9;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd[0], 32'h1234);
`else
    chk("nobypass_same_cycle", rd[0], 32'hAAAA);
`endif
    next();
    idle();
    @(negedge clk);
    chk("x9_next_cycle", rd[0], 32'h1234);

    // Mid-cycle reset after activity.
    next();
    we[0] = 1'b1; wa[0] = 5'd10; wd[0] = 32'h55; alloc = 1'b1; alloc_a = 5'd11;
    ra[0] = 5'd10; ra[1] = 5'd11;
    next();
    idle();
    #2 rst = 1'b1;
    we[0] = 1'b1; wa[0] = 5'd12; wd[0] = 32'h99;
    #1;
    chk("midrst_rd0", rd[0], 32'd0);
    chk("midrst_rbusy1", XLEN'(rbusy[1]), 32'd0);
    chk("midrst_nbusy", XLEN'(nbusy), 32'd0);
    next();
    rst = 1'b0;
    idle();
    ra[0] = 5'd12;
    @(negedge clk);
    chk("rst_edge_write_dropped", rd[0], 32'd0);

    next();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port ra  input  NRD x AW  read addresses.
REQ-008 SHALL have port rd  output  NRD x XLEN  read data.
REQ-009 SHALL have port rbusy  output  NRD  scoreboard busy bit of each read address.
REQ-010 SHALL have port we  input  NWR  write enables.
REQ-011 SHALL have port wa  input  NWR x AW  write addresses.
REQ-012 SHALL have port wd  input  NWR x XLEN  write data.
REQ-013 SHALL have port alloc  input  1  mark destination register pending.
REQ-014 SHALL have port alloc_a  input  AW  register to mark pending.
REQ-015 SHALL have port nbusy  output  AW+1  count of busy registers.

Function
REQ-016 SHALL update rf[wa[i]] <= wd[i] on clk rising edge when we[i]=1 and wa[i]!=0.
REQ-017 SHALL hardwire register 0: rd=0, rbusy=0, writes and allocs to it ignored.
REQ-018 SHALL resolve same-cycle writes to one address by highest port index winning.
REQ-019 SHALL return rd combinationally from array (zero read latency).
REQ-020 SHALL set busy[alloc_a] on the edge where alloc=1 and alloc_a!=0.
REQ-021 SHALL clear busy[wa[i]] on the edge where we[i]=1.
REQ-022 SHALL, on simultaneous alloc and write to the same register, leave busy=1 (new producer wins) while still writing data.
REQ-023 SHALL allow alloc of an already-busy register (busy stays 1, no error).
REQ-024 SHALL drive nbusy as registered popcount of busy[NREG-1:1], consistent with busy every cycle.
REQ-025 SHALL give rbusy[j] = busy[ra[j]] registered state, subject to REQ-029.

Reset
REQ-026 SHALL, while rst=1, force all registers to 0, all busy bits to 0, nbusy to 0, independent of clk.
REQ-027 SHALL discard any write or alloc presented on the edge where rst is asserted; rd reads 0 during reset.

Configuration
REQ-028 SHALL provide macro REGFILE_BYPASS_EN.
REQ-029 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to rd[j] when we[i]=1 and wa[i]=ra[j]!=0 (highest i wins) and drive rbusy[j]=0 unless alloc to the same register is also active (then 1).
REQ-030 SHALL, without REGFILE_BYPASS_EN, return only pre-edge array contents and busy state (write visible next cycle).

Structure
REQ-031 SHALL place reg-address typedef, XLEN/NREG defaults and the zero-register constant in shared package cpu_pkg.
REQ-032 SHALL implement busy bits and nbusy in sub-module reg_scoreboard (alloc/clear ports, busy vector out); data array stays in regfile_sb.

Verification
REQ-033 SHALL cover: reset, write x5=0xDEADBEEF, next cycle ra0=5 -> rd0=0xDEADBEEF, rbusy0=0.
REQ-034 SHALL cover: we=2'b11, wa={7,7}, wd={0x2222,0x1111} -> rf[7]=0x2222 next cycle.
REQ-035 SHALL cover: write x0=0xFFFFFFFF with alloc_a=0 -> rd=0, rbusy=0, nbusy=0.
REQ-036 SHALL cover: alloc x3, x4 -> nbusy=2; write x3 -> nbusy=1; alloc+write x4 same cycle -> busy[4]=1, rf[4] updated, nbusy=1.
REQ-037 SHALL cover: with bypass, ra0=9 and we0=1, wa0=9, wd0=0x1234 same cycle -> rd0=0x1234; without bypass rd0=old value, 0x1234 next cycle.
REQ-038 SHALL cover: assert rst mid-cycle after writes/allocs -> all rd=0, nbusy=0 before next edge.
